// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbitration of the register file write port between ALU and load writeback
module rf_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit MEM_FIRST = 1'b0
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              AluValid,
   input  logic [ADDR_W-1:0] AluRW,
   input  logic [DATA_W-1:0] AluData,
   output logic              AluReady,
   input  logic              MemValid,
   input  logic [ADDR_W-1:0] MemRW,
   input  logic [DATA_W-1:0] MemData,
   output logic              MemReady,
   output logic              RegWr,
   output logic [ADDR_W-1:0] RW,
   output logic [DATA_W-1:0] BusW,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   output logic              FwdA,
   output logic              FwdB
);
   logic              ptr;
   logic [ADDR_W-1:0] g_rw;
   logic [DATA_W-1:0] g_data;
   assign AluReady = !Rst && AluValid && (!MemValid || !ptr);
   assign MemReady = !Rst && MemValid && (!AluValid || ptr);
   assign g_rw     = AluReady ? AluRW : MemRW;
   assign g_data   = AluReady ? AluData : MemData;
   assign FwdA     = RegWr && (RA == RW);
   assign FwdB     = RegWr && (RB == RW);
   // a granted write to $zero is consumed but leaves RW/BusW untouched
   always_ff @(posedge Clk) begin
      if (Rst) begin
         RegWr <= 1'b0;
         RW    <= '0;
         BusW  <= '0;
         ptr   <= MEM_FIRST;
      end else if (AluReady || MemReady) begin
         ptr   <= AluReady;
         RegWr <= (g_rw != '0);
         if (g_rw != '0) begin
            RW   <= g_rw;
            BusW <= g_data;
         end
      end else begin
         RegWr <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of grant, latency, $zero drop, forwarding and reset
module tb_rf_wb_arbiter;
   logic        Clk = 1'b0;
   logic        Rst;
   logic        AluValid, MemValid;
   logic [4:0]  AluRW, MemRW, RA, RB, RW;
   logic [31:0] AluData, MemData, BusW;
   logic        AluReady, MemReady, RegWr, FwdA, FwdB;
   int          total = 0;
   int          bad = 0;
   rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MEM_FIRST(1'b0)) dut (
      .Clk(Clk), .Rst(Rst),
      .AluValid(AluValid), .AluRW(AluRW), .AluData(AluData), .AluReady(AluReady),
      .MemValid(MemValid), .MemRW(MemRW), .MemData(MemData), .MemReady(MemReady),
      .RegWr(RegWr), .RW(RW), .BusW(BusW),
      .RA(RA), .RB(RB), .FwdA(FwdA), .FwdB(FwdB)
   );
   always #5 Clk = ~Clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge Clk);
      #1;
   endtask
   initial begin
      logic       exp_alu [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
      logic [4:0] exp_rw  [8] = '{1, 8, 2, 9, 3, 10, 4, 11};
      int ai = 0;
      int mi = 0;
      Rst = 1; AluValid = 1; MemValid = 1; AluRW = 3; MemRW = 4;
      AluData = 32'h1; MemData = 32'h2; RA = 0; RB = 0;
      #1;
      chk("rst_alu_ready", AluReady, 0);
      chk("rst_mem_ready", MemReady, 0);
      tick;
      chk("rst_alu_ready2", AluReady, 0);
      chk("rst_mem_ready2", MemReady, 0);
      tick;
      Rst = 0; AluValid = 0; MemValid = 0;
      #1;
      chk("rst_regwr", RegWr, 0);
      chk("rst_rw", RW, 0);
      chk("rst_busw", BusW, 0);
      AluValid = 1; AluRW = 5; AluData = 32'hDEADBEEF;
      #1;
      chk("single_alu_ready", AluReady, 1);
      chk("single_mem_ready", MemReady, 0);
      tick;
      AluValid = 0;
      chk("single_regwr", RegWr, 1);
      chk("single_rw", RW, 5);
      chk("single_busw", BusW, 32'hDEADBEEF);
      tick;
      chk("single_idle_regwr", RegWr, 0);
      chk("single_idle_rw", RW, 5);
      chk("single_idle_busw", BusW, 32'hDEADBEEF);
      Rst = 1;
      tick;
      Rst = 0;
      for (int i = 0; i < 8; i++) begin
         AluValid = ai < 4; AluRW = 5'(1 + ai); AluData = 32'h11111111 * (ai + 1);
         MemValid = mi < 4; MemRW = 5'(8 + mi); MemData = 32'h88000000 + mi;
         #1;
         chk($sformatf("cont_alu_ready%0d", i), AluReady, exp_alu[i]);
         chk($sformatf("cont_mem_ready%0d", i), MemReady, !exp_alu[i]);
         tick;
         chk($sformatf("cont_regwr%0d", i), RegWr, 1);
         chk($sformatf("cont_rw%0d", i), RW, exp_rw[i]);
         chk($sformatf("cont_busw%0d", i), BusW,
             exp_alu[i] ? 32'h11111111 * (ai + 1) : 32'h88000000 + mi);
         if (exp_alu[i]) ai++; else mi++;
      end
      AluValid = 0;
      MemValid = 1; MemRW = 0; MemData = 32'hFFFFFFFF;
      #1;
      chk("zero_mem_ready", MemReady, 1);
      tick;
      MemValid = 0;
      chk("zero_regwr", RegWr, 0);
      chk("zero_rw", RW, 11);
      chk("zero_busw", BusW, 32'h88000003);
      AluValid = 1; AluRW = 7; AluData = 32'h1234;
      MemValid = 1; MemRW = 6; MemData = 32'h6666;
      #1;
      chk("zero_ptr_alu_ready", AluReady, 1);
      chk("zero_ptr_mem_ready", MemReady, 0);
      tick;
      AluValid = 0; MemValid = 0; RA = 7; RB = 3;
      #1;
      chk("fwd_regwr", RegWr, 1);
      chk("fwd_rw", RW, 7);
      chk("fwd_a", FwdA, 1);
      chk("fwd_b", FwdB, 0);
      RB = 7;
      #1;
      chk("fwd_b_hit", FwdB, 1);
      tick;
      chk("fwd_a_after", FwdA, 0);
      chk("fwd_b_after", FwdB, 0);
      AluValid = 1; AluRW = 9; AluData = 32'h99;
      #1;
      chk("mid_alu_ready", AluReady, 1);
      tick;
      AluValid = 0; Rst = 1; RA = 9;
      #1;
      chk("mid_pending_regwr", RegWr, 1);
      chk("mid_pending_rw", RW, 9);
      tick;
      Rst = 0;
      chk("mid_regwr", RegWr, 0);
      chk("mid_rw", RW, 0);
      chk("mid_busw", BusW, 0);
      chk("mid_fwd_a", FwdA, 0);
      AluValid = 1; MemValid = 1; AluRW = 2; MemRW = 3;
      #1;
      chk("mid_ptr_alu_ready", AluReady, 1);
      chk("mid_ptr_mem_ready", MemReady, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Arbitrates the register file's single write port between two writeback requesters: the ALU result path and the memory load path. Each requester uses a valid/ready handshake. Grants are round-robin. The winning request is registered onto RegWr/RW/BusW with a fixed 1-cycle latency. Combinational forwarding flags tell the read side when RA/RB hit the write currently presented to the register file, i.e. the value not yet visible on BusA/BusB.

Parameters:
DATA_W, 32, width of write data (BusW, AluData, MemData)
ADDR_W, 5, width of register index (RW, RA, RB, AluRW, MemRW)
MEM_FIRST, 0, round-robin pointer value after reset (0 = ALU has priority, 1 = MEM has priority)

Ports:
Clk  input  1  clock; all state updates on posedge Clk
Rst  input  1  synchronous reset, active-high (one clock; synchronous, active-high reset)
AluValid  input  1  ALU writeback request
AluRW  input  ADDR_W  ALU destination register
AluData  input  DATA_W  ALU result
AluReady  output  1  ALU request accepted this cycle
MemValid  input  1  load writeback request
MemRW  input  ADDR_W  load destination register
MemData  input  DATA_W  load data
MemReady  output  1  load request accepted this cycle
RegWr  output  1  register file write enable (registered)
RW  output  ADDR_W  register file write index (registered)
BusW  output  DATA_W  register file write data (registered)
RA  input  ADDR_W  register file read index A (snooped)
RB  input  ADDR_W  register file read index B (snooped)
FwdA  output  1  RA matches the write in flight; read side uses BusW instead of BusA
FwdB  output  1  RB matches the write in flight; read side uses BusW instead of BusB

Behaviour:
- State:
  - output register {RegWr, RW, BusW}
  - 1-bit round-robin pointer Ptr (0 = ALU preferred, 1 = MEM preferred)
- Grant (combinational):
  - Only AluValid high: AluReady=1.
  - Only MemValid high: MemReady=1.
  - Both high: the side selected by Ptr gets ready; the other gets 0.
  - Neither high: both ready outputs are 0.
  - A ready output is never high while its valid input is low.
  - AluReady and MemReady are never high together.
  - While Rst=1, both ready outputs are 0.
- Transfer: a request completes in any cycle where valid&ready are both high at posedge Clk. A requester holds RW/Data stable until accepted.
- Output register update at posedge:
  - Rst=1: RegWr=0, RW=0, BusW=0, Ptr=MEM_FIRST.
  - Grant with granted RW != 0: RegWr=1; RW and BusW take the granted requester's RW and Data.
  - Grant with granted RW == 0: RegWr=0; RW and BusW hold. The request is consumed (dropped) because $zero is never written.
  - No grant: RegWr=0; RW and BusW hold their previous values.
- Pointer: after any grant, including a dropped $zero write, Ptr points to the non-granted requester. With no grant, Ptr holds.
- Latency: a request accepted in cycle N appears as RegWr=1 in cycle N+1. The register file commits it at the end of cycle N+1. Sustained throughput is 1 write/cycle.
- Forwarding (combinational):
  - FwdA = RegWr & (RA == RW).
  - FwdB = RegWr & (RB == RW).
  - Both are 0 whenever RegWr=0, so they are never asserted for index 0.
- Fairness: with both valid continuously, grants alternate ALU, MEM, ALU, … starting from the requester selected by Ptr. Neither side waits more than 1 cycle.
- Reset mid-operation: a pending RegWr is cancelled at the reset edge. Unaccepted requests stay pending at the requesters and re-arbitrate from Ptr=MEM_FIRST after Rst falls.

Test Plan:
- Reset: Rst=1 for 2 cycles with both valid -> AluReady=MemReady=0; after Rst, RegWr=0, RW=0, BusW=0.
- Single requester: AluValid=1, AluRW=5, AluData=0xDEADBEEF for 1 cycle -> AluReady=1 that cycle; next cycle RegWr=1, RW=5, BusW=0xDEADBEEF; the cycle after, RegWr=0 and RW/BusW hold.
- Contention, MEM_FIRST=0: both valid for 4 cycles, ALU writes r1..r4 with 0x11.., MEM writes r8..r11 -> grants ALU, MEM, ALU, MEM; RW sequence r1, r8, r2, r9; no request is lost.
- $zero: MemValid=1, MemRW=0, MemData=0xFFFFFFFF -> MemReady=1; next cycle RegWr=0 and RW/BusW unchanged; Ptr now favours ALU.
- Forwarding: ALU writes r7=0x1234; during the RegWr=1 cycle set RA=7, RB=3 -> FwdA=1, FwdB=0; the cycle after, FwdA=0.
- Reset mid-flight: grant ALU r9 in cycle N, assert Rst in cycle N+1 -> RegWr=0 after that edge and r9 is never written.
